// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared widths, byte constants and FSM states for the JPEG bit packer.
// Rev 1.0
`default_nettype none

package jpeg_pkg;
  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 32;
  localparam int PTR_W  = 17;

  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] MARKER_EOI = 8'hD9;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    MARK_FF = 3'd2,
    MARK_D9 = 3'd3,
    FILL    = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

`default_nettype wire

// File: rtl/jpeg_word_assembler.sv
// jpeg_word_assembler: packs bytes big-endian into 32-bit words with a one-cycle strobe.
// Rev 1.0
`default_nettype none

module jpeg_word_assembler
  import jpeg_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [1:0]        byte_cnt
);

  logic [23:0] shift_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_q    <= '0;
      byte_cnt   <= 2'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_cnt == 2'd3) begin
          word_out   <= {shift_q, byte_in};
          word_valid <= 1'b1;
          byte_cnt   <= 2'd0;
        end else begin
          shift_q  <= {shift_q[15:0], byte_in};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: MSB-first code packing with 0xFF stuffing, flush padding and EOI.
// Rev 1.0
`default_nettype none

module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter bit ADD_EOI = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              code_valid,
  input  logic              flush,
  output logic              ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [PTR_W-1:0]  total_bytes,
  output logic              done
);

  state_t      state, state_next;
  logic [31:0] acc, acc_next, acc_app, code_mask;
  logic [5:0]  bit_cnt, bit_cnt_next, cnt_app;
  logic        stuff, stuff_next;
  logic [LEN_W-1:0] len_eff;
  logic        accept, push, counted;
  logic [7:0]  push_byte, pad_byte;
  logic [1:0]  byte_cnt;
  logic [PTR_W-1:0] total_next;

  assign ready = (state == RUN) && (bit_cnt <= 6'd16);
  assign done  = (state == DONE);

  always_comb begin
    len_eff   = (len_in > 5'd16) ? 5'd16 : len_in;
    accept    = code_valid && ready;
    code_mask = (32'd1 << len_eff) - 32'd1;
    acc_app   = acc;
    cnt_app   = bit_cnt;
    // New code lands directly below the bits already held
    if (accept && (len_eff != '0)) begin
      acc_app = acc | (({16'd0, code_in} & code_mask) << (6'd32 - bit_cnt - {1'b0, len_eff}));
      cnt_app = bit_cnt + {1'b0, len_eff};
    end

    state_next   = state;
    acc_next     = acc_app;
    bit_cnt_next = cnt_app;
    stuff_next   = stuff;
    push         = 1'b0;
    push_byte    = 8'h00;
    counted      = 1'b0;
    pad_byte     = acc[31:24] | (8'hFF >> bit_cnt);

    case (state)
      RUN, DRAIN: begin
        if (stuff) begin
          push       = 1'b1;
          push_byte  = JPEG_STUFF;
          counted    = 1'b1;
          stuff_next = 1'b0;
        end else if (bit_cnt >= 6'd8) begin
          push         = 1'b1;
          push_byte    = acc[31:24];
          counted      = 1'b1;
          stuff_next   = (acc[31:24] == MARKER_FF);
          acc_next     = acc_app << 8;
          bit_cnt_next = cnt_app - 6'd8;
        end else if ((state == DRAIN) && (bit_cnt != 6'd0)) begin
          // Trailing partial byte is completed with 1s
          push         = 1'b1;
          push_byte    = pad_byte;
          counted      = 1'b1;
          stuff_next   = (pad_byte == MARKER_FF);
          acc_next     = '0;
          bit_cnt_next = 6'd0;
        end else if (state == DRAIN) begin
          state_next = ADD_EOI ? MARK_FF : FILL;
        end
        if ((state == RUN) && flush && ready) state_next = DRAIN;
      end
      MARK_FF: begin
        push       = 1'b1;
        push_byte  = MARKER_FF;
        counted    = 1'b1;
        state_next = MARK_D9;
      end
      MARK_D9: begin
        push       = 1'b1;
        push_byte  = MARKER_EOI;
        counted    = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        // Zero-fill completes the last word but is not part of the stream length
        if (byte_cnt != 2'd0) begin
          push      = 1'b1;
          push_byte = 8'h00;
        end else begin
          state_next = DONE;
        end
      end
      default: ;
    endcase

    total_next = total_bytes + {{(PTR_W-1){1'b0}}, counted};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= RUN;
      acc         <= '0;
      bit_cnt     <= 6'd0;
      stuff       <= 1'b0;
      total_bytes <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      bit_cnt     <= bit_cnt_next;
      stuff       <= stuff_next;
      total_bytes <= total_next;
    end
  end

  jpeg_word_assembler u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .byte_in    (push_byte),
    .byte_valid (push),
    .word_out   (word_out),
    .word_valid (word_valid),
    .byte_cnt   (byte_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: directed and random stimulus against a bit-queue reference model.
// Rev 1.0
`default_nettype none

module tb_jpeg_bit_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] code_in = '0;
  logic [4:0]  len_in = '0;
  logic        code_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ready, word_valid, done;
  logic [31:0] word_out;
  logic [16:0] total_bytes;

  localparam bit TB_EOI = 1'b1;

  jpeg_bit_packer #(.ADD_EOI(TB_EOI)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .code_in     (code_in),
    .len_in      (len_in),
    .code_valid  (code_valid),
    .flush       (flush),
    .ready       (ready),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .total_bytes (total_bytes),
    .done        (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit          bits[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] got[$];
  int exp_total = 0;
  int stream_len = 0;
  int stall_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain bit queue cut into bytes
  function automatic void emit(input logic [7:0] b, input bit cnt);
    exp_bytes.push_back(b);
    stream_len++;
    if (cnt) exp_total++;
  endfunction

  function automatic void model_bytes();
    logic [7:0] b;
    while (bits.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits.pop_front()};
      emit(b, 1'b1);
      if (b == 8'hFF) emit(8'h00, 1'b1);
    end
  endfunction

  function automatic void model_code(input logic [15:0] c, input int l);
    int n;
    n = (l > 16) ? 16 : l;
    for (int i = n - 1; i >= 0; i--) bits.push_back(c[i]);
    model_bytes();
  endfunction

  function automatic void model_flush();
    if (bits.size() > 0) begin
      while (bits.size() < 8) bits.push_back(1'b1);
      model_bytes();
    end
    if (TB_EOI) begin
      emit(8'hFF, 1'b1);
      emit(8'hD9, 1'b1);
    end
    while ((stream_len % 4) != 0) emit(8'h00, 1'b0);
  endfunction

  always @(negedge clock) begin
    logic [31:0] e;
    if (reset_n && word_valid) begin
      got.push_back(word_out);
      if (exp_bytes.size() < 4) begin
        chk("word_unexpected", word_out, 32'hxxxxxxxx);
      end else begin
        for (int i = 0; i < 4; i++) e = {e[23:0], exp_bytes.pop_front()};
        chk("word_model", word_out, e);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    code_valid = 1'b0;
    flush = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    bits.delete();
    exp_bytes.delete();
    got.delete();
    exp_total = 0;
    stream_len = 0;
  endtask

  task automatic send(input logic [15:0] c, input logic [4:0] l);
    int t;
    t = 0;
    code_in = c;
    len_in = l;
    code_valid = 1'b1;
    if (!ready) stall_seen++;
    while (!ready && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 100) chk("send_timeout", {31'd0, ready}, 32'd1);
    @(posedge clock);
    #1 code_valid = 1'b0;
    model_code(c, int'(l));
  endtask

  task automatic finish_stream(input bit with_code, input logic [15:0] c, input logic [4:0] l);
    int t;
    t = 0;
    flush = 1'b1;
    if (with_code) begin
      code_in = c;
      len_in = l;
      code_valid = 1'b1;
    end
    while (!ready && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    @(posedge clock);
    #1;
    flush = 1'b0;
    code_valid = 1'b0;
    if (with_code) model_code(c, int'(l));
    model_flush();
    t = 0;
    while (!done && t < 500) begin
      @(negedge clock);
      t++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("total_bytes", {15'd0, total_bytes}, {15'd0, 17'(exp_total)});
    chk("leftover_bytes", exp_bytes.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word_out", word_out, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_total", {15'd0, total_bytes}, 32'd0);

    // Four whole bytes form exactly one word
    send(16'h00AB, 5'd8); send(16'h00CD, 5'd8);
    send(16'h0012, 5'd8); send(16'h0034, 5'd8);
    idle(6);
    chk("t1_words", got.size(), 32'd1);
    chk("t1_word", got[0], 32'hABCD1234);
    chk("t1_total", {15'd0, total_bytes}, 32'd4);

    // Stuffed 0xFF, then flush accepted together with a final code
    do_reset();
    send(16'h00FF, 5'd8); send(16'h0123, 5'd16);
    finish_stream(1'b1, 16'h0045, 5'd8);
    chk("t2_word0", got[0], 32'hFF000123);
    chk("t2_word1", got[1], 32'h45FFD900);
    chk("t2_total", {15'd0, total_bytes}, 32'd7);

    // Partial byte padded with 1s
    do_reset();
    send(16'h0005, 5'd3);
    finish_stream(1'b0, 16'h0000, 5'd0);
    chk("t3_word", got[0], 32'hBFFFD900);
    chk("t3_total", {15'd0, total_bytes}, 32'd3);

    // Pad byte becoming 0xFF is itself stuffed
    do_reset();
    send(16'h007F, 5'd7);
    finish_stream(1'b0, 16'h0000, 5'd0);
    chk("t5_word", got[0], 32'hFF00FFD9);
    chk("t5_total", {15'd0, total_bytes}, 32'd4);

    // Empty stream: marker only
    do_reset();
    finish_stream(1'b0, 16'h0000, 5'd0);
    chk("empty_word", got[0], 32'hFFD90000);
    chk("empty_total", {15'd0, total_bytes}, 32'd2);

    // Reset while two bytes are pending discards them
    do_reset();
    send(16'h00AA, 5'd8); send(16'h00BB, 5'd8);
    do_reset();
    idle(6);
    chk("t6_no_word", got.size(), 32'd0);
    chk("t6_total", {15'd0, total_bytes}, 32'd0);
    send(16'h0011, 5'd8); send(16'h0022, 5'd8);
    send(16'h0033, 5'd8); send(16'h0044, 5'd8);
    finish_stream(1'b0, 16'h0000, 5'd0);
    chk("t6_word", got[0], 32'h11223344);

    // Back-to-back 16-bit codes must back-pressure
    do_reset();
    stall_seen = 0;
    for (int i = 0; i < 40; i++) send(16'($urandom), 5'd16);
    chk("t4_stall_seen", {31'd0, (stall_seen > 0)}, 32'd1);
    finish_stream(1'b0, 16'h0000, 5'd0);

    // Random lengths (0 and >16 included) and garbage above len
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 5'($urandom_range(0, 20)));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    finish_stream(1'b1, 16'($urandom), 5'($urandom_range(1, 16)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jpeg_bit_packer.md
Name: jpeg_bit_packer

Overview:
Final entropy-coding stage, directly upstream of output_buffer.
- Accepts variable-length Huffman/amplitude codes (1..16 bits) from the entropy coder.
- Packs them MSB-first into a byte stream with JPEG 0xFF->0xFF00 stuffing.
- Groups bytes big-endian into 32-bit words and drives output_buffer's data_in/write_en.
- On flush: pads the last byte, optionally appends the EOI marker, and reports the stream length.

Parameters:
CODE_W, 16, max code width in bits
LEN_W, 5, width of code length field (0..16)
WORD_W, 32, output word width (=`BUS_SIZE/`JPEG_IN)
PTR_W, 17, width of byte counter (matches output_buffer pointers)
ADD_EOI, 1, 1 = append 0xFFD9 on flush; 0 = no marker

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
code_in  in  CODE_W  code bits, right-aligned; only low len_in bits used
len_in  in  LEN_W  bit count; 0 = accepted no-op; >16 treated as 16
code_valid  in  1  code_in/len_in valid this cycle
flush  in  1  end-of-scan request, level-sampled
ready  out  1  block accepts code_valid/flush this cycle
word_out  out  WORD_W  packed word; first stream byte in [31:24]
word_valid  out  1  one-cycle strobe; connects to output_buffer write_en
total_bytes  out  PTR_W  bytes of real stream emitted (stuff + marker included, zero-fill excluded)
done  out  1  flush complete, final word emitted

Behaviour:
- Reset (reset_n=0 at an edge): accumulator, bit_cnt, byte_cnt, total_bytes, FSM->RUN. Outputs: word_out=0, word_valid=0, done=0. ready=1 in the cycle after reset. Reset mid-stream discards partial bits and bytes silently.
- Accumulator: 32-bit MSB-aligned, bit_cnt 0..32.
  - ready = (state==RUN) && (bit_cnt<=16).
  - Accept when code_valid && ready: append low len_in bits below the existing bits.
- Byte extraction: at most one byte per edge, taken when bit_cnt>=8 and no stuff is pending.
  - The top byte goes to the word assembler; accumulator shifts left 8; bit_cnt -= 8.
  - Accept and extract in the same edge are allowed: bit_cnt_next = bit_cnt + len - 8.
- Stuffing: when an extracted data byte is 0xFF, the next byte slot is forced to 0x00. Extraction stalls that edge. Stuffing does not apply to marker bytes.
- Word assembler: shifts bytes in; on the 4th byte it registers word_out={b0,b1,b2,b3} and pulses word_valid for exactly 1 cycle, then byte_cnt returns to 0.
  - Latency: word_valid is high in the cycle after the edge that extracts the 4th byte.
  - Throughput: max 1 byte/cycle.
- total_bytes increments per data, stuff and marker byte. Wraps modulo 2^PTR_W; no saturation.
- FSM:
  - RUN: flush&&ready -> DRAIN. If code_valid is also high that cycle, the code is accepted first and included.
  - DRAIN: extract while bit_cnt>=8. When bit_cnt<8 and no stuff is pending: if bit_cnt>0, pad with 1s to 8 bits and extract; this byte is stuffed if it equals 0xFF. Then -> MARK_FF if ADD_EOI, else -> FILL.
  - MARK_FF: push 0xFF -> MARK_D9. MARK_D9: push 0xD9 -> FILL.
  - FILL: if byte_cnt!=0, push 0x00 bytes (not counted in total_bytes) until the word completes. Then -> DONE.
  - DONE: done=1, ready=0, code_valid ignored; held until reset.
- code_valid or flush while ready=0: ignored. The producer must hold its request until ready.
- Empty stream with flush and ADD_EOI=1 -> single word 0xFFD90000, total_bytes=2.

Decomposition:
- Package jpeg_pkg: CODE_W, LEN_W, WORD_W, PTR_W, JPEG_STUFF=8'h00, MARKER_FF=8'hFF, MARKER_EOI=8'hD9, FSM state enum {RUN, DRAIN, MARK_FF, MARK_D9, FILL, DONE}.
- Sub-module jpeg_word_assembler: byte in/valid -> 32-bit word/word_valid, plus byte counter. Keeps the accumulator/FSM top separate from word packing.

Test Plan:
- Codes 0xAB/8, 0xCD/8, 0x12/8, 0x34/8 on consecutive cycles -> exactly one word_valid, word_out=0xABCD1234, total_bytes=4.
- Code 0xFF/8, then 0x0123/16, then 0x45/8 -> words 0xFF000123, then after flush (ADD_EOI=1) 0x45FFD900; total_bytes=7; done=1.
- Code 0x5/3, then flush -> pad byte 0xBF, marker, fill -> word_out=0xBFFFD900, total_bytes=3.
- Back-to-back 16-bit codes every cycle -> ready drops once bit_cnt>16; no bits lost; byte stream equals software reference packing (random 1000 codes, scoreboard).
- Pad byte itself 0xFF (code 0x7F/7, flush) -> 0xFF00FFD9; total_bytes=4.
- Reset_n low for 1 cycle after 2 bytes are pending -> no word_valid, total_bytes=0. Next stream 0x11223344 is emitted cleanly.
